scie_fir_multi: RTL
===================

Name: scie_fir_multi

Overview:
- Parametrised multi-channel successor to the single-channel SCIE FIR accelerator.
- Sits behind the Rocket SCIE custom-instruction interface.
- Holds per-channel coefficient banks and sample delay lines, and runs a pipelined multiply/adder-tree MAC on every sample push.
- Returns fixed-point results on a read instruction.
- Adds channel count, tap depth, width generics, a clear op, optional saturation, and busy/valid status.

Parameters:
- XLEN, 32, width of rs1/rs2/rd.
- DATA_W, 16, sample width (unsigned).
- COEF_W, 16, coefficient width (unsigned).
- TAPS, 5, taps per channel (2..32).
- CHANNELS, 2, independent filter channels (1..8).
- FRAC_W, 16, right shift applied to accumulator (Q format of coefficients).
- Derived: ACC_W = DATA_W+COEF_W+clog2(TAPS).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_valid  in  1  instruction valid this cycle.
- io_insn  in  32  instruction; [6:0] opcode, [14:12] channel, [25] saturate flag.
- io_rs1  in  XLEN  operand: coefficient or sample value.
- io_rs2  in  XLEN  operand: tap index for coefficient write.
- io_rd  out  XLEN  read result, registered.
- io_rd_valid  out  1  one-cycle pulse, 1 cycle after an accepted READ.
- io_busy  out  1  high while any MAC is in flight in the pipeline.

Behaviour:
- Reset (reset=0, async): all coefficients, delay lines, per-channel result registers, pipeline valids, io_rd, io_rd_valid and io_busy clear to 0.
- Decode happens only when io_valid=1. The channel is ch=insn[14:12]. If ch>=CHANNELS, the op is ignored; a READ to such a channel returns 0 with io_rd_valid=1.
- Opcode 0x0B COEF_WR: coef[ch][rs2] <= rs1[COEF_W-1:0]. If rs2>=TAPS, the write is ignored.
- Opcode 0x2B PUSH:
  - The delay line shifts: x[ch][0] <= rs1[DATA_W-1:0], x[ch][k] <= x[ch][k-1]; the oldest sample is dropped.
  - A MAC for ch is launched.
- Opcode 0x5B READ: io_rd <= result[ch], or the saturated form if insn[25]=1. io_rd_valid=1 on the next cycle.
- Opcode 0x7B CLEAR:
  - Zeroes x[ch][*] and result[ch]; coefficients are kept.
  - In-flight MACs for ch are squashed (their writeback is suppressed).
- Any other opcode: no effect.
- MAC pipeline, 2 stages, fully pipelined (one PUSH accepted per cycle, no stall):
  - S1, the cycle after PUSH: register TAPS products p[k] = x_new[k]*coef[ch][k]. Products use the updated delay line and the coefficients current at the PUSH cycle.
  - S2: adder tree sum into ACC_W bits, then write result[ch] = acc >> FRAC_W, zero-extended to XLEN.
  - Result latency: a READ issued 2 cycles after PUSH returns the new value; io_rd updates 1 cycle after the READ.
- Saturation: with insn[25]=1, values above 2^DATA_W-1 read as 2^DATA_W-1. With insn[25]=0, the value is truncated to XLEN.
- Collisions:
  - READ in the same cycle as S2 writeback to the same ch returns the old result.
  - COEF_WR during an in-flight MAC does not affect it.
  - CLEAR and writeback in the same cycle: CLEAR wins.
- io_busy = OR of the S1/S2 valid bits.
- io_rd holds its value between READs.
- Reset asserted mid-operation aborts all in-flight MACs immediately.

Test Plan:
- Setup: CHANNELS=2, TAPS=5. COEF_WR ch0 taps 0..4 with 12544, 56107, 896, 51130, 9820.
  - PUSH ch0 12056, idle, READ ch0 -> io_rd=2307, io_rd_valid pulse.
  - Then PUSH 16695, idle, READ -> io_rd=13516.
- Channel isolation: after the above, READ ch1 -> 0.
  - Load ch1 tap0=65536>>1 (32768), PUSH ch1 1000, READ ch1 -> 500.
  - ch0 is unchanged (READ -> 13516).
- Back-to-back PUSHes to ch0 on consecutive cycles (6 samples, which wraps the delay line past TAPS):
  - io_busy stays high throughout.
  - Final READ matches a golden model using only the last 5 samples.
- Saturation: coefs all 65535, PUSH 65535 five times, then:
  - READ with insn[25]=1 -> 65535.
  - READ with insn[25]=0 -> floor(5*65535*65535/65536)=327670.
- CLEAR ch0 issued 1 cycle after a PUSH -> READ returns 0 (writeback squashed). Coefficients are retained, so the next PUSH 12056 -> 2307.
- Edge cases:
  - COEF_WR with rs2=7 (>=TAPS) has no effect.
  - An op with ch=5 is ignored, and its READ returns 0.
  - Asserting reset during an in-flight MAC -> all outputs 0; a subsequent READ returns 0.

Source files
------------

// File: rtl/scie_fir_multi.sv
// Multi-channel FIR accelerator behind the Rocket SCIE custom-instruction port.
// Each channel has its own coefficient bank, sample delay line and result register.
// A PUSH launches a 2-stage MAC: products are registered, then summed and written back.
module scie_fir_multi #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned TAPS     = 5,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned FRAC_W   = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_rd_valid,
  output logic            io_busy
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic [6:0] OpCoefWr = 7'h0B;
  localparam logic [6:0] OpPush   = 7'h2B;
  localparam logic [6:0] OpRead   = 7'h5B;
  localparam logic [6:0] OpClear  = 7'h7B;

  localparam logic [XLEN-1:0] SatMax = XLEN'({DATA_W{1'b1}});

  // Architectural state
  logic [COEF_W-1:0] r_coef   [CHANNELS][TAPS];
  logic [DATA_W-1:0] r_x      [CHANNELS][TAPS];
  logic [XLEN-1:0]   r_result [CHANNELS];

  // MAC pipeline state
  logic              r_s1_vld;
  logic [2:0]        r_s1_ch;
  logic [PROD_W-1:0] r_prod [TAPS];
  logic              r_s2_vld;

  logic [XLEN-1:0] r_rd;
  logic            r_rd_valid;

  // Decode
  logic [6:0]        w_op;
  logic [2:0]        w_ch;
  logic              w_sat;
  logic              w_ch_ok;
  logic              w_coef_wr;
  logic              w_push;
  logic              w_read;
  logic              w_clear;
  logic [DATA_W-1:0] w_x_sel    [TAPS];
  logic [DATA_W-1:0] w_x_new    [TAPS];
  logic [COEF_W-1:0] w_coef_sel [TAPS];
  logic [XLEN-1:0]   w_rd_sel;
  logic [XLEN-1:0]   w_rd_next;
  logic [ACC_W-1:0]  w_acc;
  logic [ACC_W-1:0]  w_shift;
  logic [XLEN-1:0]   w_res;
  logic              w_squash;
  logic              w_unused;

  assign w_op      = io_insn[6:0];
  assign w_ch      = io_insn[14:12];
  assign w_sat     = io_insn[25];
  assign w_ch_ok   = 32'(w_ch) < CHANNELS;
  assign w_coef_wr = io_valid && w_ch_ok && (w_op == OpCoefWr);
  assign w_push    = io_valid && w_ch_ok && (w_op == OpPush);
  assign w_clear   = io_valid && w_ch_ok && (w_op == OpClear);
  // Reads of a nonexistent channel still complete, returning 0
  assign w_read    = io_valid && (w_op == OpRead);
  assign w_unused  = ^{io_insn[31:26], io_insn[24:15], io_insn[11:7], io_rs1};

  // Select the addressed channel's delay line, coefficients and result
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_x_sel[k]    = '0;
      w_coef_sel[k] = '0;
    end
    w_rd_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_ch == 3'(c)) begin
        for (int k = 0; k < TAPS; k++) begin
          w_x_sel[k]    = r_x[c][k];
          w_coef_sel[k] = r_coef[c][k];
        end
        w_rd_sel = r_result[c];
      end
    end
  end

  // Delay line as it looks after this PUSH; S1 multiplies against it
  always_comb begin
    w_x_new[0] = io_rs1[DATA_W-1:0];
    for (int k = 1; k < TAPS; k++) begin
      w_x_new[k] = w_x_sel[k-1];
    end
  end

  // S2 adder tree and fixed-point scaling
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'(r_prod[k]);
    end
    w_shift = w_acc >> FRAC_W;
    w_res   = XLEN'(w_shift);
  end

  // A CLEAR to the channel being written back this cycle wins over the writeback
  assign w_squash  = w_clear && (w_ch == r_s1_ch);
  assign w_rd_next = (w_sat && (w_rd_sel > SatMax)) ? SatMax : w_rd_sel;

  // Coefficient banks; out-of-range tap indices simply match nothing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) r_coef[c][k] <= '0;
      end
    end else if (w_coef_wr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          if (w_ch == 3'(c) && io_rs2 == XLEN'(k)) r_coef[c][k] <= io_rs1[COEF_W-1:0];
        end
      end
    end
  end

  // Delay lines: shift on PUSH, zero on CLEAR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) r_x[c][k] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_ch == 3'(c)) begin
          if (w_clear) begin
            for (int k = 0; k < TAPS; k++) r_x[c][k] <= '0;
          end else if (w_push) begin
            for (int k = 0; k < TAPS; k++) r_x[c][k] <= w_x_new[k];
          end
        end
      end
    end
  end

  // S1: register per-tap products and the launching channel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s1_ch  <= '0;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
    end else begin
      r_s1_vld <= w_push;
      if (w_push) begin
        r_s1_ch <= w_ch;
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= PROD_W'(w_x_new[k]) * PROD_W'(w_coef_sel[k]);
        end
      end
    end
  end

  // S2: result writeback, overridden by CLEAR of the same channel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_vld <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_result[c] <= '0;
    end else begin
      r_s2_vld <= r_s1_vld && !w_squash;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_clear && w_ch == 3'(c)) begin
          r_result[c] <= '0;
        end else if (r_s1_vld && r_s1_ch == 3'(c)) begin
          r_result[c] <= w_res;
        end
      end
    end
  end

  // Read port: io_rd holds between READs, valid pulses once per READ
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_read;
      if (w_read) r_rd <= w_rd_next;
    end
  end

  assign io_rd       = r_rd;
  assign io_rd_valid = r_rd_valid;
  assign io_busy     = r_s1_vld || r_s2_vld;

endmodule
